// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encoding and register-file constants.
package hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;

    // Architectural zero register: never a real producer, so never a hazard source.
    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

endpackage : hazard_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset_n (sync, active-low), clr (wins over inc), inc,
//        count (holds at all-ones once reached).
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core.
// Resolves, in priority order, data-memory freezes, taken-branch redirects
// (with a fetch-refill window of REDIRECT_CYCLES) and load-use bubbles, and
// keeps saturating stall/flush performance counters.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   id_rs1/id_rs2, id_uses_rs1/2      ID-stage source operands
//   id_ex_mem_read, id_ex_rd          EX-stage load and its destination
//   ex_mem_taken                      taken control transfer resolved in MEM
//   dmem_req, dmem_ready              data-memory handshake
//   cnt_clr                           clear both counters
//   pc_we .. ex_mem_we                stage register write-enables
//   if_id/id_ex/ex_mem_flush          bubble insertion per stage register
//   stall_count, flush_count          performance counters
//   state_o                           current FSM state
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REDIRECT_CYCLES = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 id_ex_mem_read,
    input  logic [REG_IDX_W-1:0] id_ex_rd,
    input  logic                 ex_mem_taken,
    input  logic                 dmem_req,
    input  logic                 dmem_ready,
    input  logic                 cnt_clr,
    output logic                 pc_we,
    output logic                 if_id_we,
    output logic                 id_ex_we,
    output logic                 ex_mem_we,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count,
    output logic [1:0]           state_o
);

    // A zero-length refill window still needs a legal one-bit counter.
    localparam int unsigned RC_W =
        (REDIRECT_CYCLES == 0) ? 1 : $clog2(REDIRECT_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REDIRECT_CYCLES);

    hazard_state_t   state, state_nxt;
    logic [RC_W-1:0] rc_cnt, rc_cnt_nxt;
    logic            freeze;
    logic            load_use;
    logic            redirect_evt;

    assign freeze = dmem_req & ~dmem_ready;

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign load_use = id_ex_mem_read && (id_ex_rd != REG_X0) &&
                      ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    // State register and redirect down-counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= RUN;
            rc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            rc_cnt <= rc_cnt_nxt;
        end
    end

    // Next-state and stage-control decode; freeze > redirect > load-use.
    always_comb begin
        state_nxt    = state;
        rc_cnt_nxt   = rc_cnt;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        redirect_evt = 1'b0;

        if (!reset_n) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_nxt    = RUN;
            rc_cnt_nxt   = '0;
        end else if (freeze) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            // A refill window in progress is paused in place, not abandoned.
            if (state != REDIRECT) begin
                state_nxt = MEM_WAIT;
            end
        end else begin
            case (state)
                RUN: begin
                    if (ex_mem_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        redirect_evt = 1'b1;
                        if (REDIRECT_CYCLES != 0) begin
                            state_nxt  = REDIRECT;
                            rc_cnt_nxt = RC_LOAD;
                        end
                    end else if (load_use) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                REDIRECT: begin
                    // ID holds a bubble here, so hazards from it are ignored.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (rc_cnt <= RC_W'(1)) begin
                        state_nxt  = RUN;
                        rc_cnt_nxt = '0;
                    end else begin
                        rc_cnt_nxt = rc_cnt - RC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign state_o = reset_n ? state : RUN;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (~pc_we),
        .count   (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (redirect_evt),
        .count   (flush_count)
    );

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (REDIRECT_CYCLES=2, CNT_W=4).
module tb_hazard_ctrl;

    localparam int unsigned RC  = 2;
    localparam int unsigned CW  = 4;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4:0]    id_rs1, id_rs2, id_ex_rd;
    logic          id_uses_rs1, id_uses_rs2, id_ex_mem_read;
    logic          ex_mem_taken, dmem_req, dmem_ready, cnt_clr;
    logic          pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic          if_id_flush, id_ex_flush, ex_mem_flush;
    logic [CW-1:0] stall_count, flush_count;
    logic [1:0]    state_o;

    always #5 clk = ~clk;

    hazard_ctrl #(.REDIRECT_CYCLES(RC), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .ex_mem_taken   (ex_mem_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .cnt_clr        (cnt_clr),
        .pc_we          (pc_we),
        .if_id_we       (if_id_we),
        .id_ex_we       (id_ex_we),
        .ex_mem_we      (ex_mem_we),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .stall_count    (stall_count),
        .flush_count    (flush_count),
        .state_o        (state_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: mode 0=running, 1=refilling, 2=waiting on memory.
    // m_left is the number of refill cycles still owed.
    bit       mon_en = 1'b0;
    int       m_mode = 0, m_left = 0, m_sc = 0, m_fc = 0;
    int       nm, nl;
    bit       fz, lu, evt;
    logic [3:0] e_we;
    logic [2:0] e_fl;
    int       e_st;

    always @(negedge clk) begin
        if (mon_en) begin
            fz  = dmem_req && !dmem_ready;
            lu  = id_ex_mem_read && (id_ex_rd != 0) &&
                  ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
            e_we = 4'b1111;
            e_fl = 3'b000;
            e_st = m_mode;
            evt  = 1'b0;
            nm   = m_mode;
            nl   = m_left;
            if (!reset_n) begin
                e_we = 4'b0000; e_fl = 3'b111; e_st = 0; nm = 0; nl = 0;
            end else if (fz) begin
                e_we = 4'b0000;
                if (m_mode != 1) nm = 2;
            end else if (m_mode == 2) begin
                nm = 0;
            end else if (m_mode == 1) begin
                e_fl = 3'b110;
                nl   = m_left - 1;
                if (nl == 0) nm = 0;
            end else if (ex_mem_taken) begin
                e_fl = 3'b111;
                evt  = 1'b1;
                if (RC > 0) begin nm = 1; nl = RC; end
            end else if (lu) begin
                e_we = 4'b0011;
                e_fl = 3'b010;
            end

            chk("m_pc_we",        pc_we,        e_we[3]);
            chk("m_if_id_we",     if_id_we,     e_we[2]);
            chk("m_id_ex_we",     id_ex_we,     e_we[1]);
            chk("m_ex_mem_we",    ex_mem_we,    e_we[0]);
            chk("m_if_id_flush",  if_id_flush,  e_fl[2]);
            chk("m_id_ex_flush",  id_ex_flush,  e_fl[1]);
            chk("m_ex_mem_flush", ex_mem_flush, e_fl[0]);
            chk("m_state_o",      state_o,      e_st);
            chk("m_stall_count",  stall_count,  m_sc);
            chk("m_flush_count",  flush_count,  m_fc);

            if (!reset_n || cnt_clr) begin
                m_sc = 0;
                m_fc = 0;
            end else begin
                if (!e_we[3] && m_sc < SAT) m_sc++;
                if (evt && m_fc < SAT) m_fc++;
            end
            m_mode = nm;
            m_left = nl;
        end
    end

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_ex_mem_read = 0;
        ex_mem_taken = 0; dmem_req = 0; dmem_ready = 0; cnt_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
        id_ex_mem_read = 1; id_ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        tick();
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_pc_we", pc_we, 0);
        chk("rst_if_id_flush", if_id_flush, 1);
        chk("rst_state", state_o, 0);
        tick(); reset_n = 1'b1;
        @(negedge clk);
        chk("run_pc_we", pc_we, 1);
        chk("run_ex_mem_flush", ex_mem_flush, 0);

        // Load-use on rs1, then same pattern targeting x0.
        tick(); set_lu(5, 5, 0, 1, 0);
        @(negedge clk);
        chk("lu_pc_we", pc_we, 0);
        chk("lu_if_id_we", if_id_we, 0);
        chk("lu_id_ex_flush", id_ex_flush, 1);
        tick(); idle();
        @(negedge clk);
        chk("lu_stall_count", stall_count, 1);
        chk("lu_after_pc_we", pc_we, 1);
        tick(); set_lu(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("x0_pc_we", pc_we, 1);
        tick(); idle();
        @(negedge clk);
        chk("x0_stall_count", stall_count, 1);
        tick(); cnt_clr = 1;
        tick(); idle();
        @(negedge clk);
        chk("clr_stall_count", stall_count, 0);

        // Redirect with a two-cycle refill window.
        tick(); ex_mem_taken = 1;
        @(negedge clk);
        chk("rd_if_id_flush", if_id_flush, 1);
        chk("rd_ex_mem_flush", ex_mem_flush, 1);
        chk("rd_pc_we", pc_we, 1);
        tick(); idle();
        @(negedge clk);
        chk("rd1_state", state_o, 1);
        chk("rd1_id_ex_flush", id_ex_flush, 1);
        chk("rd1_ex_mem_flush", ex_mem_flush, 0);
        tick();
        @(negedge clk);
        chk("rd2_state", state_o, 1);
        tick();
        @(negedge clk);
        chk("rd_done_state", state_o, 0);
        chk("rd_done_if_id_flush", if_id_flush, 0);
        chk("rd_flush_count", flush_count, 1);

        // Three-cycle memory freeze.
        tick(); dmem_req = 1; dmem_ready = 0;
        @(negedge clk);
        chk("fz0_pc_we", pc_we, 0);
        tick();
        @(negedge clk);
        chk("fz1_state", state_o, 2);
        tick();
        @(negedge clk);
        chk("fz2_ex_mem_we", ex_mem_we, 0);
        tick(); dmem_ready = 1;
        @(negedge clk);
        chk("fz_exit_pc_we", pc_we, 1);
        chk("fz_exit_state", state_o, 2);
        tick(); idle();
        @(negedge clk);
        chk("fz_stall_count", stall_count, 3);
        chk("fz_back_state", state_o, 0);

        // Redirect beats a coincident load-use; freeze pauses the refill.
        tick(); ex_mem_taken = 1; set_lu(7, 0, 7, 0, 1);
        @(negedge clk);
        chk("pr_pc_we", pc_we, 1);
        chk("pr_ex_mem_flush", ex_mem_flush, 1);
        tick(); idle(); dmem_req = 1; dmem_ready = 0;
        @(negedge clk);
        chk("pr_stall_count", stall_count, 3);
        chk("pr_frz_state", state_o, 1);
        chk("pr_frz_pc_we", pc_we, 0);
        chk("pr_frz_if_id_flush", if_id_flush, 0);
        tick();
        @(negedge clk);
        chk("pr_frz2_state", state_o, 1);
        tick(); dmem_ready = 1;
        @(negedge clk);
        chk("pr_resume_state", state_o, 1);
        chk("pr_resume_if_id_flush", if_id_flush, 1);
        tick(); idle();
        @(negedge clk);
        chk("pr_last_state", state_o, 1);
        tick();
        @(negedge clk);
        chk("pr_done_state", state_o, 0);
        chk("pr_flush_count", flush_count, 2);
        chk("pr_stall_count_end", stall_count, 5);

        // Saturation after 20 stalls, then clear coincident with a stall.
        tick(); cnt_clr = 1;
        tick(); idle(); set_lu(9, 9, 0, 1, 0);
        repeat (19) tick();
        tick(); cnt_clr = 1;
        @(negedge clk);
        chk("sat_stall_count", stall_count, 15);
        tick(); idle();
        @(negedge clk);
        chk("sat_clr_stall_count", stall_count, 0);

        // Reset asserted in the middle of a memory wait.
        tick(); dmem_req = 1; dmem_ready = 0;
        tick();
        @(negedge clk);
        chk("rmw_pre_state", state_o, 2);
        tick(); reset_n = 1'b0;
        @(negedge clk);
        chk("rmw_pc_we", pc_we, 0);
        chk("rmw_ex_mem_flush", ex_mem_flush, 1);
        chk("rmw_state", state_o, 0);
        tick(); reset_n = 1'b1; idle();
        @(negedge clk);
        chk("rmw_rel_state", state_o, 0);
        chk("rmw_rel_stall_count", stall_count, 0);
        chk("rmw_rel_flush_count", flush_count, 0);
        chk("rmw_rel_pc_we", pc_we, 1);

        tick();
        tick();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_ctrl
